// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-add slice per cycle around a single carry flop,
// framed by a start/busy/done handshake. {cout, sum} = a + b + cin after N slices.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic         s_bit,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          s_nxt;
  logic          c_nxt;

  // Returns {carry, sum} of a one-bit full add.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  assign {c_nxt, s_nxt} = full_add(a_sr[0], b_sr[0], carry);
  assign cout = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s_bit <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            sum   <= '0;
            s_bit <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= c_nxt;
          s_bit <= s_nxt;
          sum   <= {s_nxt, sum[N-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          // Counter parks at N-1 on the last slice rather than wrapping.
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table-driven N=8 vectors with a result
// scoreboard, hand-written handshake/reset sequences, and an exhaustive N=2 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, s_bit8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, s_bit2, cout2;
  logic [1:0] a2, b2, sum2;

  int tests = 0;
  int fails = 0;

  logic [8:0] sb8[$];
  logic [2:0] sb2[$];

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [15:0] poke;
    logic [8:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  serial_adder #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s_bit(s_bit8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .s_bit(s_bit2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop8(input string nm);
    logic [8:0] e;
    if (sb8.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: done with no expected result queued, got %0h", nm, {cout8, sum8});
    end else begin
      e = sb8.pop_front();
      check({nm, "_result"}, {23'd0, cout8, sum8}, {23'd0, e});
    end
  endtask

  // Runs one N=8 addition; poke[k] drives start during the cycle after negedge k.
  task automatic do_add8(input string nm, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [15:0] poke, input logic [8:0] exp);
    int         busy_n, done_n, done_lat;
    logic [7:0] seq;
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    sb8.push_back(exp);
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    busy_n = 0; done_n = 0; done_lat = -1; seq = '0;
    for (int lat = 0; lat < 12; lat++) begin
      if (lat > 0) @(negedge clk);
      if (busy8) busy_n++;
      if (lat >= 1 && lat <= 8) seq[lat-1] = s_bit8;
      if (done8) begin
        done_n++;
        if (done_lat < 0) begin
          done_lat = lat;
          pop8(nm);
        end
      end
      start8 = poke[lat];
    end
    start8 = 1'b0;
    check({nm, "_done_lat"}, done_lat, 8);
    check({nm, "_busy_cycles"}, busy_n, 8);
    check({nm, "_done_pulses"}, done_n, 1);
    check({nm, "_s_bit_seq"}, {24'd0, seq}, {24'd0, exp[7:0]});
    check({nm, "_hold"}, {23'd0, cout8, sum8}, {23'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   lat, nd, d1, d2, dn;
    logic b9, b10;
    logic [2:0] e2;

    vecs[0] = '{"add_3c_05",   8'h3C, 8'h05, 1'b0, 16'h0000, 9'h041};
    vecs[1] = '{"ripple_ff_01", 8'hFF, 8'h01, 1'b0, 16'h0000, 9'h100};
    vecs[2] = '{"max_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 16'h0000, 9'h1FF};
    vecs[3] = '{"start_ignored", 8'h96, 8'h2B, 1'b0, 16'h0108, 9'h0C1};
    vecs[4] = '{"msb_80_80_1", 8'h80, 8'h80, 1'b1, 16'h0000, 9'h101};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs_n8", {20'd0, busy8, done8, s_bit8, cout8, sum8}, 32'd0);
    check("reset_outputs_n2", {26'd0, busy2, done2, s_bit2, cout2, sum2}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_add8(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].poke, vecs[i].exp);

    // start held high: second operation accepted N+2 cycles after the first.
    a8 = 8'h3C; b8 = 8'h05; cin8 = 1'b0; start8 = 1'b1;
    sb8.push_back(9'h041);
    nd = 0; d1 = -1; d2 = -1; b9 = 1'b1; b10 = 1'b0;
    @(negedge clk);
    for (lat = 0; lat <= 24; lat++) begin
      if (lat > 0) @(negedge clk);
      if (lat == 1) begin
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
        sb8.push_back(9'h047);
      end
      if (lat == 9) b9 = busy8;
      if (lat == 10) begin
        b10 = busy8;
        start8 = 1'b0;
      end
      if (done8) begin
        if (nd == 0) d1 = lat; else d2 = lat;
        nd++;
        pop8("held_start");
      end
    end
    check("held_busy_gap", {31'd0, b9}, 32'd0);
    check("held_second_accept", {31'd0, b10}, 32'd1);
    check("held_done1_lat", d1, 8);
    check("held_done2_lat", d2, 18);
    check("held_done_pulses", nd, 2);

    // Asynchronous reset in the middle of an addition.
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun_busy_before_reset", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {20'd0, busy8, done8, s_bit8, cout8, sum8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) dn++;
    end
    check("midrun_no_done_or_resume", dn, 0);
    do_add8("post_reset_01_01", 8'h01, 8'h01, 1'b0, 16'h0000, 9'h002);

    // Exhaustive N=2 sweep.
    for (int i = 0; i < 32; i++) begin
      a2 = i[1:0]; b2 = i[3:2]; cin2 = i[4]; start2 = 1'b1;
      sb2.push_back(3'(i[1:0]) + 3'(i[3:2]) + 3'(i[4]));
      @(negedge clk);
      start2 = 1'b0;
      a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      lat = 0;
      while (!done2 && lat < 6) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("n2_lat_%0d", i), lat, 2);
      if (done2 && sb2.size() > 0) begin
        e2 = sb2.pop_front();
        check($sformatf("n2_result_%0d", i), {29'd0, cout2, sum2}, {29'd0, e2});
      end else begin
        sb2.delete();
      end
      @(negedge clk);
    end

    check("scoreboard_drained", sb8.size() + sb2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
